// File: rtl/pwm_pkg.sv
// Shared types for the PWM peripheral family.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } pwm_cap_state_t;

endpackage : pwm_pkg

// File: rtl/pwm_capture_if.sv
// Control inputs and held measurement results of the PWM capture block.
interface pwm_capture_if #(
  parameter int unsigned CNT_W = 16
);

  logic             PWM_CLKE;
  logic             CAP_EN;
  logic             PWM_IN;
  logic [CNT_W-1:0] PERIOD;
  logic [CNT_W-1:0] HIGH_TIME;
  logic             VALID;
  logic             TIMEOUT;
  logic             STUCK_LVL;

  // slave: the capture block; master: the register bank / CPU side
  modport slave (
    input  PWM_CLKE,
    input  CAP_EN,
    input  PWM_IN,
    output PERIOD,
    output HIGH_TIME,
    output VALID,
    output TIMEOUT,
    output STUCK_LVL
  );

  modport master (
    output PWM_CLKE,
    output CAP_EN,
    output PWM_IN,
    input  PERIOD,
    input  HIGH_TIME,
    input  VALID,
    input  TIMEOUT,
    input  STUCK_LVL
  );

endinterface : pwm_capture_if

// File: rtl/pwm_in_sync.sv
// Metastability synchronizer for an asynchronous single-bit input.
// Reusable for any async peripheral input; SYNC_STAGES must be at least 2.
module pwm_in_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule : pwm_in_sync

// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM waveform in sample ticks,
// reporting a one-cycle VALID strobe with held results, or TIMEOUT on a stuck input.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic          CLK,
  input  logic          RST,
  pwm_capture_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             pin_sync;
  logic             s_q;
  logic             p_q;
  pwm_cap_state_t   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hi_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_time_q;
  logic             valid_q;
  logic             timeout_q;
  logic             stuck_lvl_q;

  logic             tick_c;
  logic             rise_c;
  logic             fall_c;
  logic             cnt_sat_c;
  logic [CNT_W-1:0] cnt_inc_c;

  pwm_in_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pwm_in_sync (
    .clk_i   (CLK),
    .rst_i   (RST),
    .async_i (bus.PWM_IN),
    .sync_o  (pin_sync)
  );

  assign tick_c    = bus.PWM_CLKE;
  assign rise_c    = s_q & ~p_q;
  assign fall_c    = ~s_q & p_q;
  assign cnt_sat_c = (cnt_q == CNT_MAX);
  // Saturating increment so a late fall at full count cannot wrap the counter
  assign cnt_inc_c = cnt_sat_c ? cnt_q : cnt_q + CNT_ONE;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_q         <= 1'b0;
      p_q         <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;

      if (tick_c) begin
        s_q <= pin_sync;
        p_q <= s_q;
      end

      if (!bus.CAP_EN) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            state_q <= WAIT_RISE;
          end

          // The partial cycle in flight at enable time is never reported
          WAIT_RISE: begin
            if (tick_c && rise_c) begin
              cnt_q   <= CNT_ONE;
              state_q <= MEAS_HIGH;
            end
          end

          MEAS_HIGH: begin
            if (tick_c) begin
              if (fall_c) begin
                hi_q    <= cnt_q;
                cnt_q   <= cnt_inc_c;
                state_q <= MEAS_LOW;
              end else if (cnt_sat_c) begin
                timeout_q   <= 1'b1;
                stuck_lvl_q <= s_q;
                cnt_q       <= '0;
                state_q     <= WAIT_RISE;
              end else begin
                cnt_q <= cnt_inc_c;
              end
            end
          end

          // A terminating edge takes priority over saturation on the same tick
          MEAS_LOW: begin
            if (tick_c) begin
              if (rise_c) begin
                period_q    <= cnt_q;
                high_time_q <= hi_q;
                valid_q     <= 1'b1;
                cnt_q       <= CNT_ONE;
                state_q     <= MEAS_HIGH;
              end else if (cnt_sat_c) begin
                timeout_q   <= 1'b1;
                stuck_lvl_q <= s_q;
                cnt_q       <= '0;
                state_q     <= WAIT_RISE;
              end else begin
                cnt_q <= cnt_inc_c;
              end
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.PERIOD    = period_q;
  assign bus.HIGH_TIME = high_time_q;
  assign bus.VALID     = valid_q;
  assign bus.TIMEOUT   = timeout_q;
  assign bus.STUCK_LVL = stuck_lvl_q;

endmodule : pwm_capture

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture: a 16-bit instance for the measurement
// scenarios and a 4-bit instance for the saturation/timeout scenario.
module tb_pwm_capture;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pwm_capture_if #(.CNT_W(16)) if16 ();
  pwm_capture_if #(.CNT_W(4))  if4  ();

  pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) u_dut16 (
    .CLK (clk),
    .RST (rst),
    .bus (if16)
  );

  pwm_capture #(.CNT_W(4), .SYNC_STAGES(2)) u_dut4 (
    .CLK (clk),
    .RST (rst),
    .bus (if4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for the next posedge, then return at the following negedge
  task automatic drive(input logic pwm, input logic ce);
    if16.PWM_IN   = pwm;
    if16.PWM_CLKE = ce;
    @(negedge clk);
  endtask

  task automatic flush();
    if16.CAP_EN = 1'b0;
    repeat (6) drive(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) drive(1'b0, 1'b0);
    checks++; if (if16.PERIOD !== 16'd0) begin errors++; $display("FAIL reset_period16 got %0d exp 0", if16.PERIOD); end
    checks++; if (if16.HIGH_TIME !== 16'd0) begin errors++; $display("FAIL reset_high16 got %0d exp 0", if16.HIGH_TIME); end
    checks++; if (if16.VALID !== 1'b0) begin errors++; $display("FAIL reset_valid16 got %b exp 0", if16.VALID); end
    checks++; if (if16.TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout16 got %b exp 0", if16.TIMEOUT); end
    checks++; if (if16.STUCK_LVL !== 1'b0) begin errors++; $display("FAIL reset_stuck16 got %b exp 0", if16.STUCK_LVL); end
    checks++; if (if4.PERIOD !== 4'd0) begin errors++; $display("FAIL reset_period4 got %0d exp 0", if4.PERIOD); end
    checks++; if (if4.HIGH_TIME !== 4'd0) begin errors++; $display("FAIL reset_high4 got %0d exp 0", if4.HIGH_TIME); end
    checks++; if (if4.VALID !== 1'b0) begin errors++; $display("FAIL reset_valid4 got %b exp 0", if4.VALID); end
    checks++; if (if4.TIMEOUT !== 1'b0) begin errors++; $display("FAIL reset_timeout4 got %b exp 0", if4.TIMEOUT); end
    checks++; if (if4.STUCK_LVL !== 1'b0) begin errors++; $display("FAIL reset_stuck4 got %b exp 0", if4.STUCK_LVL); end
    rst = 1'b0;
  endtask

  // Tick every CLK, period 10 high 3: VALID at cycles 13, 23, ..., 93
  task automatic test_basic();
    int nv = 0;
    int nto = 0;
    int last = -1;
    if16.CAP_EN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(logic'((i % 10) < 3), 1'b1);
      if (if16.TIMEOUT) nto++;
      if (if16.VALID) begin
        checks++; if (if16.PERIOD !== 16'd10) begin errors++; $display("FAIL basic_period i=%0d got %0d exp 10", i, if16.PERIOD); end
        checks++; if (if16.HIGH_TIME !== 16'd3) begin errors++; $display("FAIL basic_high i=%0d got %0d exp 3", i, if16.HIGH_TIME); end
        checks++;
        if (last < 0) begin
          if (i !== 13) begin errors++; $display("FAIL basic_first_valid got cycle %0d exp 13", i); end
        end else if (i - last !== 10) begin
          errors++; $display("FAIL basic_interval got %0d exp 10", i - last);
        end
        last = i;
        nv++;
      end
    end
    checks++; if (nv !== 9) begin errors++; $display("FAIL basic_valid_count got %0d exp 9", nv); end
    checks++; if (nto !== 0) begin errors++; $display("FAIL basic_timeout_count got %0d exp 0", nto); end
  endtask

  // Tick every 4th CLK, period 40 high 20: PERIOD 10, HIGH_TIME 5, VALID at 48, 88, ..., 368
  task automatic test_prescaled();
    int nv = 0;
    int nto = 0;
    int last = -1;
    flush();
    if16.CAP_EN = 1'b1;
    for (int i = 0; i < 400; i++) begin
      drive(logic'((i % 40) < 20), logic'((i % 4) == 0));
      if (if16.TIMEOUT) nto++;
      if (if16.VALID) begin
        checks++; if (if16.PERIOD !== 16'd10) begin errors++; $display("FAIL presc_period i=%0d got %0d exp 10", i, if16.PERIOD); end
        checks++; if (if16.HIGH_TIME !== 16'd5) begin errors++; $display("FAIL presc_high i=%0d got %0d exp 5", i, if16.HIGH_TIME); end
        checks++;
        if (last < 0) begin
          if (i !== 48) begin errors++; $display("FAIL presc_first_valid got cycle %0d exp 48", i); end
        end else if (i - last !== 40) begin
          errors++; $display("FAIL presc_interval got %0d exp 40", i - last);
        end
        last = i;
        nv++;
      end
    end
    checks++; if (nv !== 9) begin errors++; $display("FAIL presc_valid_count got %0d exp 9", nv); end
    checks++; if (nto !== 0) begin errors++; $display("FAIL presc_timeout_count got %0d exp 0", nto); end
  endtask

  // 4-bit counter, input held high: TIMEOUT at 18, then again only after a new rise (at 83)
  task automatic test_saturation();
    int nto = 0;
    int nv = 0;
    if16.CAP_EN = 1'b0;
    if4.CAP_EN   = 1'b1;
    if4.PWM_CLKE = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if4.PWM_IN = (i >= 60 && i < 65) ? 1'b0 : 1'b1;
      drive(1'b0, 1'b0);
      if (if4.VALID) nv++;
      if (if4.TIMEOUT) begin
        checks++;
        if (nto == 0 && i !== 18) begin errors++; $display("FAIL sat_first_timeout got cycle %0d exp 18", i); end
        else if (nto == 1 && i !== 83) begin errors++; $display("FAIL sat_second_timeout got cycle %0d exp 83", i); end
        else if (nto > 1) begin errors++; $display("FAIL sat_extra_timeout at cycle %0d", i); end
        nto++;
      end
      if (i == 40) begin
        checks++; if (if4.STUCK_LVL !== 1'b1) begin errors++; $display("FAIL sat_stuck_lvl got %b exp 1", if4.STUCK_LVL); end
      end
    end
    checks++; if (nto !== 2) begin errors++; $display("FAIL sat_timeout_count got %0d exp 2", nto); end
    checks++; if (nv !== 0) begin errors++; $display("FAIL sat_valid_count got %0d exp 0", nv); end
    if4.CAP_EN   = 1'b0;
    if4.PWM_CLKE = 1'b0;
    if4.PWM_IN   = 1'b0;
  endtask

  // Drop CAP_EN in MEAS_LOW, then re-enable with period 12 high 5
  task automatic test_cap_disable();
    int nv = 0;
    int first = -1;
    flush();
    if16.CAP_EN = 1'b1;
    for (int i = 0; i < 18; i++) drive(logic'((i % 10) < 3), 1'b1);
    checks++; if (if16.PERIOD !== 16'd10) begin errors++; $display("FAIL dis_pre_period got %0d exp 10", if16.PERIOD); end
    if16.CAP_EN = 1'b0;
    for (int i = 18; i < 30; i++) begin
      drive(logic'((i % 10) < 3), 1'b1);
      if (if16.VALID || if16.TIMEOUT) nv++;
    end
    checks++; if (nv !== 0) begin errors++; $display("FAIL dis_strobe_count got %0d exp 0", nv); end
    checks++; if (if16.PERIOD !== 16'd10) begin errors++; $display("FAIL dis_held_period got %0d exp 10", if16.PERIOD); end
    checks++; if (if16.HIGH_TIME !== 16'd3) begin errors++; $display("FAIL dis_held_high got %0d exp 3", if16.HIGH_TIME); end
    if16.CAP_EN = 1'b1;
    for (int j = 0; j < 30; j++) begin
      drive(logic'((j % 12) < 5), 1'b1);
      if (if16.VALID && first < 0) begin
        first = j;
        checks++; if (if16.PERIOD !== 16'd12) begin errors++; $display("FAIL reen_period got %0d exp 12", if16.PERIOD); end
        checks++; if (if16.HIGH_TIME !== 16'd5) begin errors++; $display("FAIL reen_high got %0d exp 5", if16.HIGH_TIME); end
      end
    end
    checks++; if (first !== 15) begin errors++; $display("FAIL reen_first_valid got cycle %0d exp 15", first); end
  endtask

  // RST during MEAS_HIGH clears outputs; measurement restarts with VALID at cycle 33
  task automatic test_reset_mid();
    int first = -1;
    flush();
    if16.CAP_EN = 1'b1;
    for (int i = 0; i < 14; i++) drive(logic'((i % 10) < 3), 1'b1);
    checks++; if (if16.PERIOD !== 16'd10) begin errors++; $display("FAIL rstmid_pre_period got %0d exp 10", if16.PERIOD); end
    rst = 1'b1;
    drive(1'b0, 1'b1);
    checks++; if (if16.PERIOD !== 16'd0) begin errors++; $display("FAIL rstmid_period got %0d exp 0", if16.PERIOD); end
    checks++; if (if16.HIGH_TIME !== 16'd0) begin errors++; $display("FAIL rstmid_high got %0d exp 0", if16.HIGH_TIME); end
    checks++; if (if16.VALID !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", if16.VALID); end
    checks++; if (if16.TIMEOUT !== 1'b0) begin errors++; $display("FAIL rstmid_timeout got %b exp 0", if16.TIMEOUT); end
    rst = 1'b0;
    for (int i = 15; i < 40; i++) begin
      drive(logic'((i % 10) < 3), 1'b1);
      if (if16.VALID && first < 0) begin
        first = i;
        checks++; if (if16.PERIOD !== 16'd10) begin errors++; $display("FAIL rstmid_new_period got %0d exp 10", if16.PERIOD); end
        checks++; if (if16.HIGH_TIME !== 16'd3) begin errors++; $display("FAIL rstmid_new_high got %0d exp 3", if16.HIGH_TIME); end
      end
    end
    checks++; if (first !== 33) begin errors++; $display("FAIL rstmid_first_valid got cycle %0d exp 33", first); end
  endtask

  // Tick every 8th CLK, period 64 high 32, with 1-CLK glitches between ticks
  task automatic test_glitch();
    int nv = 0;
    int last = -1;
    logic pwm;
    flush();
    if16.CAP_EN = 1'b1;
    for (int i = 0; i < 256; i++) begin
      pwm = logic'((i % 64) < 32);
      if ((i % 64) == 11) pwm = 1'b0;
      if ((i % 64) == 43) pwm = 1'b1;
      drive(pwm, logic'((i % 8) == 0));
      if (if16.VALID) begin
        checks++; if (if16.PERIOD !== 16'd8) begin errors++; $display("FAIL glitch_period i=%0d got %0d exp 8", i, if16.PERIOD); end
        checks++; if (if16.HIGH_TIME !== 16'd4) begin errors++; $display("FAIL glitch_high i=%0d got %0d exp 4", i, if16.HIGH_TIME); end
        checks++;
        if (last < 0) begin
          if (i !== 80) begin errors++; $display("FAIL glitch_first_valid got cycle %0d exp 80", i); end
        end else if (i - last !== 64) begin
          errors++; $display("FAIL glitch_interval got %0d exp 64", i - last);
        end
        last = i;
        nv++;
      end
    end
    checks++; if (nv !== 3) begin errors++; $display("FAIL glitch_valid_count got %0d exp 3", nv); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    if16.CAP_EN   = 1'b0;
    if16.PWM_IN   = 1'b0;
    if16.PWM_CLKE = 1'b0;
    if4.CAP_EN    = 1'b0;
    if4.PWM_IN    = 1'b0;
    if4.PWM_CLKE  = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_prescaled();
    test_saturation();
    test_cap_disable();
    test_reset_mid();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_pwm_capture
